// File: rtl/border_draw_ctrl.sv
// rtl/border_draw_ctrl.sv - border draw/erase sequencer feeding the 160x120 vga_adapter
// Walks top, bottom, left, right edges one pixel per step_en; start/done handshake.
module border_draw_ctrl #(
  parameter logic [7:0] X_MIN  = 8'd15,
  parameter logic [7:0] X_MAX  = 8'd144,
  parameter logic [6:0] Y_TOP  = 7'd20,
  parameter logic [6:0] Y_BOT  = 7'd105,
  parameter logic [2:0] COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       erase,
  input  logic       step_en,
  input  logic       abort,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [6:0] Y_FIRST = Y_TOP + 7'd1;
  localparam logic [6:0] Y_LAST  = Y_BOT - 7'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_BOTTOM,
    S_LEFT,
    S_RIGHT,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] col;
  // set on the final RIGHT pixel so done lands one cycle after the last plot
  logic       last_px;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cx      <= 8'd0;
      cy      <= 7'd0;
      col     <= 3'b000;
      last_px <= 1'b0;
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'b000;
      plot    <= 1'b0;
      done    <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_TOP;
            cx      <= X_MIN;
            cy      <= Y_TOP;
            col     <= erase ? 3'b000 : COLOUR;
            last_px <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          if (abort) begin
            state   <= S_IDLE;
            last_px <= 1'b0;
          end else if (last_px) begin
            state   <= S_DONE;
            done    <= 1'b1;
            last_px <= 1'b0;
          end else if (step_en) begin
            x      <= cx;
            y      <= cy;
            colour <= col;
            plot   <= 1'b1;
            case (state)
              S_TOP: begin
                if (cx == X_MAX) begin
                  state <= S_BOTTOM;
                  cx    <= X_MIN;
                  cy    <= Y_BOT;
                end else begin
                  cx <= cx + 8'd1;
                end
              end
              S_BOTTOM: begin
                if (cx == X_MAX) begin
                  state <= S_LEFT;
                  cx    <= X_MIN;
                  cy    <= Y_FIRST;
                end else begin
                  cx <= cx + 8'd1;
                end
              end
              S_LEFT: begin
                if (cy == Y_LAST) begin
                  state <= S_RIGHT;
                  cx    <= X_MAX;
                  cy    <= Y_FIRST;
                end else begin
                  cy <= cy + 7'd1;
                end
              end
              S_RIGHT: begin
                if (cy == Y_LAST) begin
                  last_px <= 1'b1;
                end else begin
                  cy <= cy + 7'd1;
                end
              end
              default: begin
                state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_border_draw_ctrl.sv
// tb/tb_border_draw_ctrl.sv - directed self-checking bench for border_draw_ctrl
module tb_border_draw_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       erase;
  logic       step_en;
  logic       abort;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int pass_cnt = 0;
  int total_cnt = 0;

  int exp_x [0:427];
  int exp_y [0:427];
  int cap_x [0:511];
  int cap_y [0:511];
  int cap_c [0:511];
  int ncap;
  int ndone;
  int first_cyc;
  int last_cyc;
  logic adj;
  logic done_after_last;
  logic busy_after_done;
  logic timed_out;

  border_draw_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .erase   (erase),
    .step_en (step_en),
    .abort   (abort),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected();
    int n;
    n = 0;
    for (int i = 15; i <= 144; i++) begin exp_x[n] = i;   exp_y[n] = 20;  n++; end
    for (int i = 15; i <= 144; i++) begin exp_x[n] = i;   exp_y[n] = 105; n++; end
    for (int i = 21; i <= 104; i++) begin exp_x[n] = 15;  exp_y[n] = i;   n++; end
    for (int i = 21; i <= 104; i++) begin exp_x[n] = 144; exp_y[n] = i;   n++; end
  endtask

  function automatic int coord_errors();
    int e;
    e = 0;
    for (int i = 0; i < 428; i++)
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i]) e++;
    return e;
  endfunction

  function automatic int colour_errors(input int c);
    int e;
    e = 0;
    for (int i = 0; i < 428; i++)
      if (cap_c[i] != c) e++;
    return e;
  endfunction

  // Starts a pass and records every plotted pixel until done, then watches a few idle cycles.
  task automatic run_pass(input logic er, input int period, input logic toggle_er,
                          input logic restart_mid);
    int cnt;
    logic prev_plot;
    logic prev_done;
    logic restarted;
    ncap = 0; ndone = 0; adj = 1'b0; done_after_last = 1'b0; busy_after_done = 1'b1;
    first_cyc = -1; last_cyc = -1; timed_out = 1'b0;
    prev_plot = 1'b0; prev_done = 1'b0; restarted = 1'b0; cnt = 0;
    erase = er; start = 1'b1; step_en = 1'b0;
    cyc();
    start = 1'b0;
    while (1) begin
      step_en = (cnt % period == 0);
      cnt++;
      cyc();
      start = 1'b0;
      if (prev_done) begin
        busy_after_done = busy;
        break;
      end
      if (plot) begin
        if (prev_plot) adj = 1'b1;
        if (ncap < 512) begin
          cap_x[ncap] = int'(x);
          cap_y[ncap] = int'(y);
          cap_c[ncap] = int'(colour);
        end
        if (first_cyc < 0) first_cyc = cnt;
        last_cyc = cnt;
        ncap++;
      end
      if (done) begin
        ndone++;
        if (prev_plot && ncap == 428) done_after_last = 1'b1;
      end
      if (toggle_er) erase = ~erase;
      if (restart_mid && !restarted && ncap == 200) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      prev_plot = plot;
      prev_done = done;
      if (cnt > 5000) begin
        timed_out = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done) ndone++;
      if (plot) ncap++;
    end
    step_en = 1'b0;
    erase = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; erase = 1'b0; step_en = 1'b0; abort = 1'b0;
    cyc(); cyc();
    total_cnt++; if (x !== 8'd0) $display("FAIL reset_x got %0d want 0", x); else pass_cnt++;
    total_cnt++; if (y !== 7'd0) $display("FAIL reset_y got %0d want 0", y); else pass_cnt++;
    total_cnt++; if (colour !== 3'd0) $display("FAIL reset_colour got %0d want 0", colour); else pass_cnt++;
    total_cnt++; if (plot !== 1'b0) $display("FAIL reset_plot got %b want 0", plot); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    step_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    total_cnt++; if (busy !== 1'b0 || plot !== 1'b0)
      $display("FAIL idle_no_start got busy=%b plot=%b want 0 0", busy, plot); else pass_cnt++;
    step_en = 1'b0;
  endtask

  task automatic test_full_pass();
    run_pass(1'b0, 1, 1'b0, 1'b0);
    total_cnt++; if (timed_out !== 1'b0) $display("FAIL full_timeout got %b want 0", timed_out); else pass_cnt++;
    total_cnt++; if (ncap != 428) $display("FAIL full_count got %0d want 428", ncap); else pass_cnt++;
    total_cnt++; if (last_cyc - first_cyc + 1 != 428)
      $display("FAIL full_consecutive got span %0d want 428", last_cyc - first_cyc + 1); else pass_cnt++;
    total_cnt++; if (cap_x[0] != 15 || cap_y[0] != 20 || cap_c[0] != 7)
      $display("FAIL full_first got (%0d,%0d,%0d) want (15,20,7)", cap_x[0], cap_y[0], cap_c[0]); else pass_cnt++;
    total_cnt++; if (cap_x[129] != 144 || cap_y[129] != 20)
      $display("FAIL full_130th got (%0d,%0d) want (144,20)", cap_x[129], cap_y[129]); else pass_cnt++;
    total_cnt++; if (cap_x[130] != 15 || cap_y[130] != 105)
      $display("FAIL full_131st got (%0d,%0d) want (15,105)", cap_x[130], cap_y[130]); else pass_cnt++;
    total_cnt++; if (cap_x[260] != 15 || cap_y[260] != 21)
      $display("FAIL full_261st got (%0d,%0d) want (15,21)", cap_x[260], cap_y[260]); else pass_cnt++;
    total_cnt++; if (cap_x[344] != 144 || cap_y[344] != 21)
      $display("FAIL full_345th got (%0d,%0d) want (144,21)", cap_x[344], cap_y[344]); else pass_cnt++;
    total_cnt++; if (cap_x[427] != 144 || cap_y[427] != 104)
      $display("FAIL full_last got (%0d,%0d) want (144,104)", cap_x[427], cap_y[427]); else pass_cnt++;
    total_cnt++; if (coord_errors() != 0)
      $display("FAIL full_order got %0d bad pixels want 0", coord_errors()); else pass_cnt++;
    total_cnt++; if (colour_errors(7) != 0)
      $display("FAIL full_colour got %0d bad colours want 0", colour_errors(7)); else pass_cnt++;
    total_cnt++; if (ndone != 1 || done_after_last !== 1'b1)
      $display("FAIL full_done got pulses=%0d after_last=%b want 1 1", ndone, done_after_last); else pass_cnt++;
    total_cnt++; if (busy_after_done !== 1'b0)
      $display("FAIL full_busy_after_done got %b want 0", busy_after_done); else pass_cnt++;
  endtask

  task automatic test_slow_step();
    run_pass(1'b0, 4, 1'b0, 1'b0);
    total_cnt++; if (timed_out !== 1'b0) $display("FAIL slow_timeout got %b want 0", timed_out); else pass_cnt++;
    total_cnt++; if (ncap != 428) $display("FAIL slow_count got %0d want 428", ncap); else pass_cnt++;
    total_cnt++; if (coord_errors() != 0)
      $display("FAIL slow_order got %0d bad pixels want 0", coord_errors()); else pass_cnt++;
    total_cnt++; if (adj !== 1'b0) $display("FAIL slow_adjacent got %b want 0", adj); else pass_cnt++;
    total_cnt++; if (ndone != 1 || done_after_last !== 1'b1)
      $display("FAIL slow_done got pulses=%0d after_last=%b want 1 1", ndone, done_after_last); else pass_cnt++;
  endtask

  task automatic test_erase();
    run_pass(1'b1, 1, 1'b1, 1'b0);
    total_cnt++; if (ncap != 428) $display("FAIL erase_count got %0d want 428", ncap); else pass_cnt++;
    total_cnt++; if (colour_errors(0) != 0)
      $display("FAIL erase_colour got %0d bad colours want 0", colour_errors(0)); else pass_cnt++;
    total_cnt++; if (coord_errors() != 0)
      $display("FAIL erase_order got %0d bad pixels want 0", coord_errors()); else pass_cnt++;
  endtask

  task automatic test_start_in_bottom();
    run_pass(1'b0, 1, 1'b0, 1'b1);
    total_cnt++; if (ncap != 428) $display("FAIL restart_count got %0d want 428", ncap); else pass_cnt++;
    total_cnt++; if (ndone != 1) $display("FAIL restart_done got %0d pulses want 1", ndone); else pass_cnt++;
    total_cnt++; if (coord_errors() != 0)
      $display("FAIL restart_order got %0d bad pixels want 0", coord_errors()); else pass_cnt++;
  endtask

  task automatic test_abort();
    int n;
    int guard;
    int bad;
    n = 0; guard = 0; bad = 0;
    start = 1'b1; step_en = 1'b1;
    cyc();
    start = 1'b0;
    while (n < 50 && guard < 200) begin
      cyc();
      if (plot) n++;
      guard++;
    end
    total_cnt++; if (n != 50) $display("FAIL abort_reach50 got %0d plots want 50", n); else pass_cnt++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    total_cnt++; if (plot !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_stop got plot=%b busy=%b want 0 0", plot, busy); else pass_cnt++;
    total_cnt++; if (x !== 8'd64 || y !== 7'd20)
      $display("FAIL abort_hold got (%0d,%0d) want (64,20)", x, y); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done || plot || busy) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL abort_quiet got %0d active cycles want 0", bad); else pass_cnt++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    total_cnt++; if (plot !== 1'b1 || x !== 8'd15 || y !== 7'd20)
      $display("FAIL abort_restart got plot=%b (%0d,%0d) want 1 (15,20)", plot, x, y); else pass_cnt++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    step_en = 1'b0;
  endtask

  task automatic test_reset_mid_left();
    int n;
    int guard;
    int bad;
    n = 0; guard = 0; bad = 0;
    start = 1'b1; step_en = 1'b1;
    cyc();
    start = 1'b0;
    while (n < 300 && guard < 600) begin
      cyc();
      if (plot) n++;
      guard++;
    end
    total_cnt++; if (n != 300 || x !== 8'd15)
      $display("FAIL rst_left_reach got n=%0d x=%0d want 300 15", n, x); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0)
      $display("FAIL rst_async_xyc got (%0d,%0d,%0d) want (0,0,0)", x, y, colour); else pass_cnt++;
    total_cnt++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_async_ctl got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done); else pass_cnt++;
    cyc();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (plot || busy || done) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL rst_no_activity got %0d active cycles want 0", bad); else pass_cnt++;
    step_en = 1'b0;
  endtask

  initial begin
    build_expected();
    test_reset();
    test_full_pass();
    test_slow_step();
    test_erase();
    test_start_in_bottom();
    test_abort();
    test_reset_mid_left();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
